compressor4to2_bist: RTL and testbench

- Built-in self-test controller for the compressor4to2 cell in the multiplier datapath.
- Sequentially drives all 16 input vectors {a3,a2,a1,a0} into a DUT instance.
- Waits a programmable settle time for each vector, then samples sout/cout and compares them against a golden model.
- Reports pass/fail, the number of failing vectors, and the first failing vector. Sits beside the compressor array as a production and bring-up checker.

---
 rtl/compressor4to2_bist.sv | 113 +++++++++++
 tb/tb_compressor4to2_bist.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/compressor4to2_bist.sv
// Built-in self-test controller for the 4:2 compressor cell: walks all 16
// input vectors, checks sout/cout against a golden model and keeps results.
module compressor4to2_bist #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_sout,
    input  logic       dut_cout,
    output logic [3:0] test_vec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_count,
    output logic       first_fail_valid,
    output logic [3:0] first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [2:0] ones;
    logic       exp_sout;
    logic       exp_cout;
    logic       mismatch;
    logic       sample;
    logic [4:0] fail_next;

    // Golden model for the vector currently on the DUT inputs.
    always_comb begin
        ones = 3'd0;
        for (int b = 0; b < 4; b++) begin
            ones = ones + {2'b00, test_vec[b]};
        end
        exp_sout  = ^test_vec;
        exp_cout  = (ones >= 3'd2);
        mismatch  = (dut_sout != exp_sout) || (dut_cout != exp_cout);
        sample    = (settle_cnt == SETTLE_LAST);
        fail_next = fail_count + {4'd0, mismatch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            settle_cnt       <= 4'd0;
            test_vec         <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= 5'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= RUN;
                        settle_cnt       <= 4'd0;
                        test_vec         <= 4'd0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        fail_count       <= 5'd0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= 4'd0;
                    end
                end
                RUN: begin
                    // Abort takes priority over the sample due on this edge.
                    if (abort) begin
                        state      <= IDLE;
                        settle_cnt <= 4'd0;
                        test_vec   <= 4'd0;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                    end else if (sample) begin
                        settle_cnt <= 4'd0;
                        fail_count <= fail_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= test_vec;
                        end
                        if (test_vec == 4'hF) begin
                            state    <= DONE;
                            test_vec <= 4'd0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (fail_next == 5'd0);
                        end else begin
                            test_vec <= test_vec + 4'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compressor4to2_bist.sv
// Self-checking bench: two BIST instances (settle 1 and 3) checked every cycle
// against a vector-index model, plus directed scenario checks.
module tb_compressor4to2_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic abort;
    int   faultMode;

    logic [3:0] tv[2];
    logic       busyO[2];
    logic       doneO[2];
    logic       passO[2];
    logic [4:0] fcO[2];
    logic       ffvO[2];
    logic [3:0] ffvecO[2];
    logic       soutI[2];
    logic       coutI[2];

    int tests = 0;
    int fails = 0;

    function automatic logic goldSout(input logic [3:0] v);
        return ^v;
    endfunction

    function automatic logic goldCout(input logic [3:0] v);
        return $countones(v) >= 2;
    endfunction

    // Behavioural compressor with optional stuck-at faults (1: sout=0, 2: cout=1).
    function automatic logic faultSout(input logic [3:0] v, input int mode);
        return (mode == 1) ? 1'b0 : goldSout(v);
    endfunction

    function automatic logic faultCout(input logic [3:0] v, input int mode);
        return (mode == 2) ? 1'b1 : goldCout(v);
    endfunction

    function automatic int settleOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    assign soutI[0] = faultSout(tv[0], faultMode);
    assign coutI[0] = faultCout(tv[0], faultMode);
    assign soutI[1] = faultSout(tv[1], faultMode);
    assign coutI[1] = faultCout(tv[1], faultMode);

    compressor4to2_bist #(.SETTLE_CYCLES(1)) dutA (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_sout(soutI[0]), .dut_cout(coutI[0]),
        .test_vec(tv[0]), .busy(busyO[0]), .done(doneO[0]), .pass(passO[0]),
        .fail_count(fcO[0]), .first_fail_valid(ffvO[0]), .first_fail_vec(ffvecO[0])
    );

    compressor4to2_bist #(.SETTLE_CYCLES(3)) dutB (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_sout(soutI[1]), .dut_cout(coutI[1]),
        .test_vec(tv[1]), .busy(busyO[1]), .done(doneO[1]), .pass(passO[1]),
        .fail_count(fcO[1]), .first_fail_valid(ffvO[1]), .first_fail_vec(ffvecO[1])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a run is a count of elapsed busy cycles; vector = cycles / (settle+1).
    bit mValid = 1'b0;
    bit mBusy[2];
    bit mDone[2];
    bit mPass[2];
    bit mFfv[2];
    bit mVecKnown[2];
    int mK[2];
    int mVec[2];
    int mFail[2];
    int mFfvec[2];
    int mPer;
    int mV;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mPer = settleOf(i) + 1;
            if (rst) begin
                mBusy[i] = 1'b0; mDone[i] = 1'b0; mPass[i] = 1'b0; mFfv[i] = 1'b0;
                mVecKnown[i] = 1'b1; mK[i] = 0; mVec[i] = 0; mFail[i] = 0; mFfvec[i] = 0;
                mValid = 1'b1;
            end else if (mValid) begin
                mDone[i] = 1'b0;
                if (!mBusy[i]) begin
                    if (start) begin
                        mBusy[i] = 1'b1; mPass[i] = 1'b0; mFfv[i] = 1'b0; mVecKnown[i] = 1'b1;
                        mK[i] = 0; mVec[i] = 0; mFail[i] = 0; mFfvec[i] = 0;
                    end
                end else if (abort) begin
                    mBusy[i] = 1'b0;
                    mPass[i] = 1'b0;
                    mVecKnown[i] = 1'b0;
                end else begin
                    if ((mK[i] + 1) % mPer == 0) begin
                        mV = mK[i] / mPer;
                        if (faultSout(4'(mV), faultMode) != goldSout(4'(mV)) ||
                            faultCout(4'(mV), faultMode) != goldCout(4'(mV))) begin
                            mFail[i]++;
                            if (!mFfv[i]) begin
                                mFfv[i] = 1'b1;
                                mFfvec[i] = mV;
                            end
                        end
                    end
                    mK[i]++;
                    if (mK[i] == 16 * mPer) begin
                        mBusy[i] = 1'b0;
                        mDone[i] = 1'b1;
                        mPass[i] = (mFail[i] == 0);
                        mVec[i] = 0;
                    end else begin
                        mVec[i] = mK[i] / mPer;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            for (int i = 0; i < 2; i++) begin
                if (mVecKnown[i]) checkOutput($sformatf("test_vec[%0d]", i), int'(tv[i]), mVec[i]);
                checkOutput($sformatf("busy[%0d]", i), int'(busyO[i]), int'(mBusy[i]));
                checkOutput($sformatf("done[%0d]", i), int'(doneO[i]), int'(mDone[i]));
                checkOutput($sformatf("pass[%0d]", i), int'(passO[i]), int'(mPass[i]));
                checkOutput($sformatf("fail_count[%0d]", i), int'(fcO[i]), mFail[i]);
                checkOutput($sformatf("first_fail_valid[%0d]", i), int'(ffvO[i]), int'(mFfv[i]));
                checkOutput($sformatf("first_fail_vec[%0d]", i), int'(ffvecO[i]), mFfvec[i]);
            end
        end
    end

    int busyCycles[2] = '{0, 0};
    int donePulses[2] = '{0, 0};
    int busyBase[2];
    int doneBase[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busyO[i]) busyCycles[i]++;
            if (doneO[i]) donePulses[i]++;
        end
    end

    task automatic applyStimulus(input int mode);
        @(posedge clk);
        #1;
        busyBase = busyCycles;
        doneBase = donePulses;
        faultMode = mode;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic checkIdleReset(input int i);
        checkOutput($sformatf("rst busy[%0d]", i), int'(busyO[i]), 0);
        checkOutput($sformatf("rst done[%0d]", i), int'(doneO[i]), 0);
        checkOutput($sformatf("rst pass[%0d]", i), int'(passO[i]), 0);
        checkOutput($sformatf("rst test_vec[%0d]", i), int'(tv[i]), 0);
        checkOutput($sformatf("rst fail_count[%0d]", i), int'(fcO[i]), 0);
        checkOutput($sformatf("rst ffv[%0d]", i), int'(ffvO[i]), 0);
        checkOutput($sformatf("rst ffvec[%0d]", i), int'(ffvecO[i]), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; faultMode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdleReset(0);
        checkIdleReset(1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Good DUT: 32 busy cycles, single done, clean pass.
        applyStimulus(0);
        repeat (36) @(negedge clk);
        checkOutput("good busy len", busyCycles[0] - busyBase[0], 32);
        checkOutput("good done cnt", donePulses[0] - doneBase[0], 1);
        checkOutput("good pass", int'(passO[0]), 1);
        checkOutput("good fail_count", int'(fcO[0]), 0);
        checkOutput("good ffv", int'(ffvO[0]), 0);

        // sout stuck at 0: odd-parity vectors fail.
        applyStimulus(1);
        repeat (36) @(negedge clk);
        checkOutput("sout0 fail_count", int'(fcO[0]), 8);
        checkOutput("sout0 pass", int'(passO[0]), 0);
        checkOutput("sout0 ffv", int'(ffvO[0]), 1);
        checkOutput("sout0 ffvec", int'(ffvecO[0]), 1);

        // cout stuck at 1: vectors 0,1,2,4,8 fail.
        applyStimulus(2);
        repeat (36) @(negedge clk);
        checkOutput("cout1 fail_count", int'(fcO[0]), 5);
        checkOutput("cout1 ffvec", int'(ffvecO[0]), 0);
        checkOutput("cout1 pass", int'(passO[0]), 0);

        // Second start in cycle 10 is ignored.
        applyStimulus(0);
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("restart busy len", busyCycles[0] - busyBase[0], 32);
        checkOutput("restart done cnt", donePulses[0] - doneBase[0], 1);
        checkOutput("restart pass", int'(passO[0]), 1);
        checkOutput("restart fail_count", int'(fcO[0]), 0);

        // Abort in cycle 12 with sout stuck at 0.
        applyStimulus(1);
        repeat (11) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", int'(busyO[0]), 0);
        checkOutput("abort pass", int'(passO[0]), 0);
        checkOutput("abort fail_count", int'(fcO[0]), 3);
        checkOutput("abort ffvec", int'(ffvecO[0]), 1);
        repeat (40) @(negedge clk);
        checkOutput("abort busy len", busyCycles[0] - busyBase[0], 12);
        checkOutput("abort done cnt", donePulses[0] - doneBase[0], 0);

        // Reset mid-run, then a clean run on both instances.
        applyStimulus(0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkIdleReset(0);
        checkIdleReset(1);
        rst = 1'b0;
        applyStimulus(0);
        repeat (70) @(negedge clk);
        checkOutput("s3 busy len", busyCycles[1] - busyBase[1], 64);
        checkOutput("s3 done cnt", donePulses[1] - doneBase[1], 1);
        checkOutput("s3 pass", int'(passO[1]), 1);
        checkOutput("s3 fail_count", int'(fcO[1]), 0);
        checkOutput("s1 busy len", busyCycles[0] - busyBase[0], 32);
        checkOutput("s1 pass", int'(passO[0]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
